// File: rtl/branch_target_buffer.sv
// Branch target buffer: fully associative, full-PC tagged predictor.
//
// Ports
//   clk            - sole clock, rising edge
//   reset          - asynchronous active-low reset
//   lookup         - lookup request; lookup_pc is the PC to look up
//   pred_valid     - registered; a lookup was presented last cycle
//   pred_hit       - registered; a valid entry matched lookup_pc
//   pred_taken     - registered; hit and the entry's counter MSB is set
//   pred_target    - registered; stored target of the matching entry
//   update         - resolved-branch update request
//   update_pc      - resolved branch PC
//   update_target  - resolved target
//   update_taken   - resolved outcome
//   flush          - start invalidation of every entry
//   flush_busy     - flush sequence in progress
//
// FSM
//   state   | meaning
//   IDLE    | normal lookup/update operation
//   FLUSH   | clearing one valid bit per cycle, entries 0..DEPTH-1
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_taken,
    input  logic                  flush,
    output logic                  flush_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      flush_idx_q, flush_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_q [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_q [DEPTH];

    logic                  pred_valid_q, pred_hit_q, pred_taken_q;
    logic [ADDR_WIDTH-1:0] pred_target_q;

    logic                  lk_hit, up_hit, inv_any;
    logic [IDX_W-1:0]      lk_idx, up_idx, inv_idx;
    logic                  busy, upd_en, wr_hit, alloc, use_rr;
    logic [IDX_W-1:0]      victim;
    logic [CTR_WIDTH-1:0]  ctr_cur, ctr_upd;
    logic                  hit_d, taken_d;
    logic [ADDR_WIDTH-1:0] target_d;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        up_hit  = 1'b0;
        up_idx  = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == lookup_pc)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == update_pc)) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

    assign busy   = (state_q == S_FLUSH);
    // Flush wins over a same-cycle update; updates are ignored while flushing.
    assign upd_en = update && !busy && !flush;
    assign wr_hit = upd_en && up_hit;
    assign alloc  = upd_en && !up_hit && update_taken;
    assign victim = inv_any ? inv_idx : rr_ptr_q;
    assign use_rr = alloc && !inv_any;

    always_comb begin
        ctr_cur = ctr_q[up_idx];
        ctr_upd = ctr_cur;
        if (update_taken) begin
            if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + CTR_WIDTH'(1);
        end else begin
            if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_WIDTH'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        valid_d     = valid_q;
        rr_ptr_d    = use_rr ? (rr_ptr_q + IDX_W'(1)) : rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d     = S_FLUSH;
                    flush_idx_d = '0;
                end else if (alloc) begin
                    valid_d[victim] = 1'b1;
                end
            end
            S_FLUSH: begin
                valid_d[flush_idx_q] = 1'b0;
                if (flush_idx_q == LAST_IDX) begin
                    state_d     = S_IDLE;
                    flush_idx_d = '0;
                end else begin
                    flush_idx_d = flush_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                flush_idx_d = '0;
            end
        endcase
    end

    // Lookups see the pre-update table; hits are suppressed while flushing.
    always_comb begin
        hit_d    = lookup && !busy && lk_hit;
        taken_d  = hit_d && ctr_q[lk_idx][CTR_WIDTH-1];
        target_d = hit_d ? tgt_q[lk_idx] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            flush_idx_q   <= '0;
            rr_ptr_q      <= '0;
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_idx_q   <= flush_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            valid_q       <= valid_d;
            pred_valid_q  <= lookup;
            pred_hit_q    <= hit_d;
            pred_taken_q  <= taken_d;
            pred_target_q <= target_d;
        end
    end

    // Payload is never cleared; the valid bits alone decide visibility.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            tgt_q[up_idx] <= update_target;
            ctr_q[up_idx] <= ctr_upd;
        end else if (alloc) begin
            tag_q[victim] <= update_pc;
            tgt_q[victim] <= update_target;
            ctr_q[victim] <= CTR_MAX;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign flush_busy  = busy;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          lookup = 1'b0;
    logic [AW-1:0] lookup_pc = '0;
    logic          pred_valid, pred_hit, pred_taken;
    logic [AW-1:0] pred_target;
    logic          update = 1'b0;
    logic [AW-1:0] update_pc = '0;
    logic [AW-1:0] update_target = '0;
    logic          update_taken = 1'b0;
    logic          flush = 1'b0;
    logic          flush_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CTR_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .lookup(lookup), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update(update), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken),
        .flush(flush), .flush_busy(flush_busy)
    );

    // Reference model: a table of entries plus a count of flush cycles remaining.
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    int          m_rr;
    int          m_busy;
    logic        e_v, e_h, e_t, e_b;
    logic [31:0] e_tgt;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_rr   = 0;
        m_busy = 0;
    endtask

    function automatic int find(logic [31:0] pc);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic model_step();
        int k, v;
        e_v = lookup; e_h = 0; e_t = 0; e_tgt = 0;
        if (lookup && m_busy == 0) begin
            k = find(lookup_pc);
            if (k >= 0) begin
                e_h = 1; e_tgt = m_tgt[k];
                e_t = (m_ctr[k] >= (CMAX + 1) / 2);
            end
        end
        if (m_busy > 0) begin
            m_valid[DEPTH - m_busy] = 0;
            m_busy--;
        end else if (flush) begin
            m_busy = DEPTH;
        end else if (update) begin
            k = find(update_pc);
            if (k >= 0) begin
                m_tgt[k] = update_target;
                m_ctr[k] = update_taken ? ((m_ctr[k] < CMAX) ? m_ctr[k] + 1 : CMAX)
                                        : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            end else if (update_taken) begin
                v = -1;
                for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) v = i;
                if (v < 0) begin
                    v = m_rr;
                    m_rr = (m_rr + 1) % DEPTH;
                end
                m_valid[v] = 1; m_tag[v] = update_pc; m_tgt[v] = update_target; m_ctr[v] = CMAX;
            end
        end
        e_b = (m_busy > 0);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic lk, logic [31:0] lpc, logic up, logic [31:0] upc,
                         logic [31:0] utgt, logic ut, logic fl);
        lookup = lk; lookup_pc = lpc; update = up; update_pc = upc;
        update_target = utgt; update_taken = ut; flush = fl;
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".valid"},  {31'b0, pred_valid}, {31'b0, e_v});
        chk({tag, ".hit"},    {31'b0, pred_hit},   {31'b0, e_h});
        chk({tag, ".taken"},  {31'b0, pred_taken}, {31'b0, e_t});
        chk({tag, ".target"}, pred_target,         e_tgt);
        chk({tag, ".busy"},   {31'b0, flush_busy}, {31'b0, e_b});
    endtask

    task automatic cyc_lk(string tag, logic [31:0] pc, logic eh);
        drive(1, pc, 0, 0, 0, 0, 0);
        run_cycle();
        chk(tag, {31'b0, pred_hit}, {31'b0, eh});
    endtask

    task automatic cyc_up(logic [31:0] pc, logic [31:0] tgt, logic tk);
        drive(0, 0, 1, pc, tgt, tk, 0);
        run_cycle();
    endtask

    typedef struct {
        logic lk; logic [31:0] lpc;
        logic up; logic [31:0] upc; logic [31:0] utgt; logic ut; logic fl;
        logic xv; logic xh; logic xt; logic [31:0] xtgt; logic xb;
    } vec_t;

    function automatic vec_t mk(logic lk, logic [31:0] lpc, logic up, logic [31:0] upc,
                                logic [31:0] utgt, logic ut, logic xv, logic xh,
                                logic xt, logic [31:0] xtgt);
        vec_t r;
        r.lk = lk; r.lpc = lpc; r.up = up; r.upc = upc; r.utgt = utgt; r.ut = ut;
        r.fl = 0; r.xv = xv; r.xh = xh; r.xt = xt; r.xtgt = xtgt; r.xb = 0;
        return r;
    endfunction

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        string nm;

        tbl[0]  = mk(1, 32'h100, 1, 32'h300, 32'h999, 0, 1, 0, 0, 32'h0);
        tbl[1]  = mk(1, 32'h300, 0, 0,       0,       0, 1, 0, 0, 32'h0);
        tbl[2]  = mk(0, 0,       1, 32'h100, 32'h200, 1, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 32'h100, 0, 0,       0,       0, 1, 1, 1, 32'h200);
        tbl[4]  = mk(0, 0,       1, 32'h100, 32'h200, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(0, 0,       1, 32'h100, 32'h200, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 32'h100, 0, 0,       0,       0, 1, 1, 0, 32'h200);
        tbl[7]  = mk(0, 0,       1, 32'h100, 32'h200, 0, 0, 0, 0, 32'h0);
        tbl[8]  = mk(1, 32'h100, 0, 0,       0,       0, 1, 1, 0, 32'h200);
        tbl[9]  = mk(0, 0,       1, 32'h300, 32'h999, 0, 0, 0, 0, 32'h0);
        tbl[10] = mk(1, 32'h300, 0, 0,       0,       0, 1, 0, 0, 32'h0);
        tbl[11] = mk(1, 32'h400, 1, 32'h400, 32'h444, 1, 1, 0, 0, 32'h0);
        tbl[12] = mk(1, 32'h400, 0, 0,       0,       0, 1, 1, 1, 32'h444);
        tbl[13] = mk(1, 32'h100, 1, 32'h100, 32'h208, 1, 1, 1, 0, 32'h200);
        tbl[14] = mk(1, 32'h100, 0, 0,       0,       0, 1, 1, 0, 32'h208);
        tbl[15] = mk(0, 0,       1, 32'h100, 32'h208, 1, 0, 0, 0, 32'h0);
        tbl[16] = mk(1, 32'h100, 0, 0,       0,       0, 1, 1, 1, 32'h208);

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid",  {31'b0, pred_valid}, 32'h0);
        chk("rst.busy",   {31'b0, flush_busy}, 32'h0);
        chk("rst.target", pred_target, 32'h0);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].lk, tbl[i].lpc, tbl[i].up, tbl[i].upc, tbl[i].utgt, tbl[i].ut, tbl[i].fl);
            run_cycle();
            nm = $sformatf("vec%0d", i);
            chk({nm, ".valid"},  {31'b0, pred_valid}, {31'b0, tbl[i].xv});
            chk({nm, ".hit"},    {31'b0, pred_hit},   {31'b0, tbl[i].xh});
            chk({nm, ".taken"},  {31'b0, pred_taken}, {31'b0, tbl[i].xt});
            chk({nm, ".target"}, pred_target,         tbl[i].xtgt);
            chk({nm, ".busy"},   {31'b0, flush_busy}, {31'b0, tbl[i].xb});
        end

        // Round-robin replacement on a fresh, full table
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc_up(32'h10, 32'h1010, 1);
        cyc_up(32'h20, 32'h2020, 1);
        cyc_up(32'h30, 32'h3030, 1);
        cyc_up(32'h40, 32'h4040, 1);
        cyc_up(32'h50, 32'h5050, 1);
        cyc_lk("rr.0x10_evicted", 32'h10, 0);
        cyc_lk("rr.0x50_hit", 32'h50, 1);
        chk("rr.0x50_target", pred_target, 32'h5050);
        cyc_lk("rr.0x20_kept", 32'h20, 1);
        cyc_up(32'h60, 32'h6060, 1);
        cyc_lk("rr.0x20_evicted", 32'h20, 0);
        cyc_lk("rr.0x60_hit", 32'h60, 1);
        cyc_lk("rr.0x30_kept", 32'h30, 1);

        // Flush of a full table, updates and lookups during busy
        drive(0, 0, 1, 32'h70, 32'h7070, 1, 1);
        run_cycle();
        check_model("flush.start");
        busy_cycles = 0;
        for (int i = 0; i < 20 && flush_busy; i++) begin
            busy_cycles++;
            drive(1, 32'h30, 1, 32'h30, 32'h3131, (i % 2) == 0, 1);
            run_cycle();
            chk("flush.lookup_miss", {31'b0, pred_hit}, 32'h0);
        end
        chk("flush.busy_cycles", busy_cycles, DEPTH);
        cyc_lk("flush.0x30_miss", 32'h30, 0);
        cyc_lk("flush.0x50_miss", 32'h50, 0);
        cyc_lk("flush.0x60_miss", 32'h60, 0);
        cyc_lk("flush.0x70_miss", 32'h70, 0);
        cyc_lk("flush.0x40_miss", 32'h40, 0);

        // Reset asserted mid-flush, between clock edges
        cyc_up(32'h10, 32'hA0, 1);
        cyc_up(32'h20, 32'hB0, 1);
        drive(1, 32'h10, 0, 0, 0, 0, 1);
        run_cycle();
        check_model("rflush.start");
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        run_cycle();
        check_model("rflush.busy");
        #2;
        reset = 1'b0;
        #1;
        chk("rflush.async.valid",  {31'b0, pred_valid}, 32'h0);
        chk("rflush.async.hit",    {31'b0, pred_hit},   32'h0);
        chk("rflush.async.taken",  {31'b0, pred_taken}, 32'h0);
        chk("rflush.async.target", pred_target,         32'h0);
        chk("rflush.async.busy",   {31'b0, flush_busy}, 32'h0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc_lk("rflush.0x10_miss", 32'h10, 0);
        chk("rflush.not_resumed", {31'b0, flush_busy}, 32'h0);
        cyc_lk("rflush.0x20_miss", 32'h20, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, 32'($urandom_range(1, 8) * 16),
                  $urandom_range(0, 9) < 4, 32'($urandom_range(1, 8) * 16),
                  $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            run_cycle();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
